hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard-detection and stall controller for the 5-stage MIPS pipeline. It compares the instruction in the D stage against the instructions in E and M, and drives the stage controls. On a stall it holds PC and the F/D register and drives `DE_reset`, the synchronous clear of the D/E pipeline register, so a bubble (IR=0) enters E. It also tracks the multi-cycle mult/div unit with an internal busy counter, so that HI/LO instructions wait until the unit is free.

## Interface
- No parameters. Latencies are fixed: `MULT_CYC` = 5, `DIV_CYC` = 10 (localparams).
- `clk`  in  1  pipeline clock; single clock domain.
- `reset`  in  1  synchronous, active-high; clears the busy counter.
- `D_IR`  in  32  instruction word in the D stage (F/D register output).
- `E_IR`  in  32  instruction word in the E stage (D/E register output).
- `M_IR`  in  32  instruction word in the M stage (E/M register output).
- `PC_en`  out  1  PC write enable; 0 while stalling.
- `FD_en`  out  1  F/D register write enable; 0 while stalling.
- `DE_reset`  out  1  synchronous clear of the D/E register; 1 while stalling.
- `md_busy`  out  1  1 while the mult/div unit is counting down.
- `stall`  out  1  raw stall indication: `PC_en` = `FD_en` = ~`stall`, `DE_reset` = `stall`.

## Operation
- **Decode classes** (identical decoder for D, E and M):
  - cal_r: addu, subu
  - cal_i: ori, lui
  - load: lw
  - store: sw
  - br: beq
  - jr
  - jal
  - md: mult, multu, div, divu
  - mf: mfhi, mflo
  - mt: mthi, mtlo
  - All other encodings, including 0x00000000, are nop.
- **Destination register:**
  - cal_r and mf: rd
  - cal_i and load: rt
  - jal: 31
  - otherwise: 0
  - Destination 0 never causes a stall.
- **Tuse** of the D-stage instruction:
  - rs: br and jr = 0; cal_r, cal_i, load, store, md and mt = 1; otherwise none.
  - rt: br = 0; cal_r and md = 1; store = 2; otherwise none.
- **Tnew:**
  - E stage: load = 2; cal_r, cal_i and mf = 1; jal = 0.
  - M stage: load = 1; all others = 0.
- **Data stall.** For stage X in {E, M}, a data stall occurs when both hold:
  - the X-stage destination is nonzero and equals the D-stage rs (or rt), and
  - Tuse(rs or rt) < Tnew_X.
- **Busy counter** (`cnt`, 4 bits):
  - At a posedge where E_IR is mult/multu: `cnt` <= 5.
  - At a posedge where E_IR is div/divu: `cnt` <= 10.
  - Else if `cnt` != 0: `cnt` <= `cnt` - 1.
  - `md_busy` = (`cnt` != 0).
- **MD stall.** An MD stall occurs when D_IR is in md, mf or mt, and either E_IR is in md (start cycle) or `md_busy` = 1.
- **Combined.** `stall` = data stall | MD stall, combinational from the current IRs and `cnt`.

## Timing
- Reset:
  - `cnt` = 0 and `md_busy` = 0 at the first posedge with `reset` high.
  - With all IRs = 0: `stall` = 0, `PC_en` = 1, `FD_en` = 1, `DE_reset` = 0.
- All outputs except `cnt` are combinational, with zero latency from the IR inputs.
- A stall lasts exactly as long as its condition holds. Each stalled cycle inserts one bubble into E while D holds its instruction.
- Load-use gap:
  - lw in E, dependent cal_r in D: 1 stall cycle.
  - lw in E, dependent beq in D: 2 stall cycles (E, then M).
- A cal_r in E with a dependent beq/jr in D gives 1 stall cycle. A cal_r in M with the same dependent D-stage instruction gives no stall (forwarded).
- Mult/div busy window:
  - mult in E at cycle t.
  - `md_busy` is high for cycles t+1 .. t+5.
  - An mf in D is stalled for cycles t .. t+5 and released at t+6.
  - For div, the window is t+1 .. t+10.
- A new md in E while `cnt` != 0 reloads the counter (the last start wins). This cannot occur under correct stalling and is still defined.
- Reset mid-count clears `cnt` at that posedge. `md_busy` = 0 in the next cycle.
- Data stall and MD stall in the same cycle give a single `stall` = 1; the outputs are not additive.

## Test plan
- **Reset.** `reset` = 1 with E_IR = mult, then release with all IRs = 0 → `md_busy` = 0, `PC_en` = 1, `DE_reset` = 0.
- **Load-use.** E_IR = lw $8,0($0), D_IR = addu $9,$8,$1 → `stall` = 1. Same D_IR with lw moved to M_IR and E_IR = 0 → `stall` = 0.
- **Branch after lw.** E_IR = lw $8, D_IR = beq $8,$0 → `stall` = 1. With the lw in M_IR → `stall` = 1. With the lw beyond M → `stall` = 0.
- **$0 and store data.**
  - E_IR = ori $0,$0,1, D_IR = beq $0,$0 → `stall` = 0.
  - E_IR = lw $5, D_IR = sw $5,0($2) → `stall` = 0 (rt Tuse 2 ≥ Tnew 2).
- **Div window.** E_IR = div $1,$2 at cycle t with D_IR = mflo $3 held constant; after t, E_IR = 0.
  - `stall` = 1 for cycles t .. t+10; `stall` = 0 at t+11.
  - `md_busy` is high exactly for t+1 .. t+10.
- **Reset mid-count.** mult start, then `reset` after 2 cycles → `md_busy` = 0 in the following cycle, and the mfhi in D releases.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard detection and stall control for the 5-stage MIPS pipeline.
// Compares D against E/M by Tuse/Tnew and tracks the multi-cycle mult/div unit.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_IR,
    input  logic [31:0] E_IR,
    input  logic [31:0] M_IR,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_reset,
    output logic        md_busy,
    output logic        stall
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;
    localparam logic [1:0]  T_NONE   = 2'd3;

    typedef enum logic [3:0] {
        C_NOP, C_CAL_R, C_CAL_I, C_LOAD, C_STORE, C_BR,
        C_JR, C_JAL, C_MD, C_MF, C_MT
    } iclass_t;

    function automatic iclass_t decode(input logic [31:0] ir);
        iclass_t c;
        c = C_NOP;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h21, 6'h23:               c = C_CAL_R;
                    6'h08:                      c = C_JR;
                    6'h18, 6'h19, 6'h1a, 6'h1b: c = C_MD;
                    6'h10, 6'h12:               c = C_MF;
                    6'h11, 6'h13:               c = C_MT;
                    default:                    c = C_NOP;
                endcase
            end
            6'h0d, 6'h0f: c = C_CAL_I;
            6'h23:        c = C_LOAD;
            6'h2b:        c = C_STORE;
            6'h04:        c = C_BR;
            6'h03:        c = C_JAL;
            default:      c = C_NOP;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] dest(input logic [31:0] ir);
        logic [4:0] r;
        r = 5'd0;
        case (decode(ir))
            C_CAL_R, C_MF:  r = ir[15:11];
            C_CAL_I, C_LOAD: r = ir[20:16];
            C_JAL:          r = 5'd31;
            default:        r = 5'd0;
        endcase
        return r;
    endfunction

    // T_NONE (3) exceeds every Tnew, so an unused source can never stall.
    function automatic logic [1:0] tuse_rs_of(input iclass_t c);
        logic [1:0] t;
        t = T_NONE;
        case (c)
            C_BR, C_JR: t = 2'd0;
            C_CAL_R, C_CAL_I, C_LOAD, C_STORE, C_MD, C_MT: t = 2'd1;
            default: t = T_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tuse_rt_of(input iclass_t c);
        logic [1:0] t;
        t = T_NONE;
        case (c)
            C_BR:          t = 2'd0;
            C_CAL_R, C_MD: t = 2'd1;
            C_STORE:       t = 2'd2;
            default:       t = T_NONE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tnew_e_of(input iclass_t c);
        logic [1:0] t;
        t = 2'd0;
        case (c)
            C_LOAD:                t = 2'd2;
            C_CAL_R, C_CAL_I, C_MF: t = 2'd1;
            default:               t = 2'd0;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tnew_m_of(input iclass_t c);
        return (c == C_LOAD) ? 2'd1 : 2'd0;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    iclass_t          d_cls;
    iclass_t          e_cls;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       e_dst;
    logic [4:0]       m_dst;
    logic [1:0]       tuse_rs;
    logic [1:0]       tuse_rt;
    logic [1:0]       e_tnew;
    logic [1:0]       m_tnew;
    logic             e_hit;
    logic             m_hit;
    logic             md_stall;

    // Busy counter: last md start in E wins, otherwise count down to zero.
    always_comb begin
        cnt_next = cnt;
        if (decode(E_IR) == C_MD) begin
            cnt_next = (E_IR[1]) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    always_comb begin
        d_cls    = decode(D_IR);
        e_cls    = decode(E_IR);
        d_rs     = D_IR[25:21];
        d_rt     = D_IR[20:16];
        e_dst    = dest(E_IR);
        m_dst    = dest(M_IR);
        tuse_rs  = tuse_rs_of(d_cls);
        tuse_rt  = tuse_rt_of(d_cls);
        e_tnew   = tnew_e_of(e_cls);
        m_tnew   = tnew_m_of(decode(M_IR));
        md_busy  = (cnt != '0);
        e_hit    = (e_dst != 5'd0) &&
                   (((e_dst == d_rs) && (tuse_rs < e_tnew)) ||
                    ((e_dst == d_rt) && (tuse_rt < e_tnew)));
        m_hit    = (m_dst != 5'd0) &&
                   (((m_dst == d_rs) && (tuse_rs < m_tnew)) ||
                    ((m_dst == d_rt) && (tuse_rt < m_tnew)));
        md_stall = ((d_cls == C_MD) || (d_cls == C_MF) || (d_cls == C_MT)) &&
                   ((e_cls == C_MD) || md_busy);
        stall    = e_hit || m_hit || md_stall;
        PC_en    = ~stall;
        FD_en    = ~stall;
        DE_reset = stall;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios then random IR mixes,
// checked against a mnemonic-level reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_IR;
    logic [31:0] E_IR;
    logic [31:0] M_IR;
    logic        PC_en;
    logic        FD_en;
    logic        DE_reset;
    logic        md_busy;
    logic        stall;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .D_IR(D_IR), .E_IR(E_IR), .M_IR(M_IR),
        .PC_en(PC_en), .FD_en(FD_en), .DE_reset(DE_reset),
        .md_busy(md_busy), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic chk;
        logic stall;
        logic busy;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_until = -1;
    bit   done     = 0;

    function automatic logic [31:0] rtype(input logic [5:0] fn, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic string mn(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h21: return "addu";
                6'h23: return "subu";
                6'h08: return "jr";
                6'h18: return "mult";
                6'h19: return "multu";
                6'h1a: return "div";
                6'h1b: return "divu";
                6'h10: return "mfhi";
                6'h12: return "mflo";
                6'h11: return "mthi";
                6'h13: return "mtlo";
                default: return "nop";
            endcase
        end
        case (op)
            6'h0d: return "ori";
            6'h0f: return "lui";
            6'h23: return "lw";
            6'h2b: return "sw";
            6'h04: return "beq";
            6'h03: return "jal";
            default: return "nop";
        endcase
    endfunction

    function automatic int dest(input logic [31:0] ir);
        string n;
        n = mn(ir);
        if (n == "addu" || n == "subu" || n == "mfhi" || n == "mflo") return int'(ir[15:11]);
        if (n == "ori" || n == "lui" || n == "lw") return int'(ir[20:16]);
        if (n == "jal") return 31;
        return 0;
    endfunction

    function automatic int tuse_rs(input string n);
        if (n == "beq" || n == "jr") return 0;
        if (n == "addu" || n == "subu" || n == "ori" || n == "lui" || n == "lw" || n == "sw" ||
            n == "mult" || n == "multu" || n == "div" || n == "divu" || n == "mthi" || n == "mtlo")
            return 1;
        return 99;
    endfunction

    function automatic int tuse_rt(input string n);
        if (n == "beq") return 0;
        if (n == "addu" || n == "subu" || n == "mult" || n == "multu" || n == "div" || n == "divu") return 1;
        if (n == "sw") return 2;
        return 99;
    endfunction

    function automatic int tnew_e(input string n);
        if (n == "lw") return 2;
        if (n == "addu" || n == "subu" || n == "ori" || n == "lui" || n == "mfhi" || n == "mflo") return 1;
        return 0;
    endfunction

    function automatic bit is_md(input string n);
        return n == "mult" || n == "multu" || n == "div" || n == "divu";
    endfunction

    function automatic bit uses_hilo(input string n);
        return is_md(n) || n == "mfhi" || n == "mflo" || n == "mthi" || n == "mtlo";
    endfunction

    // Does a producer writing reg dst, ready in tnew cycles, block D?
    function automatic bit blocks(input logic [31:0] d, input int dst, input int tnew);
        string n;
        n = mn(d);
        if (dst == 0) return 0;
        if (dst == int'(d[25:21]) && tuse_rs(n) < tnew) return 1;
        if (dst == int'(d[20:16]) && tuse_rt(n) < tnew) return 1;
        return 0;
    endfunction

    function automatic bit model_stall(input logic [31:0] d, e, m, input bit busy);
        bit data_s;
        bit md_s;
        data_s = blocks(d, dest(e), tnew_e(mn(e))) ||
                 blocks(d, dest(m), (mn(m) == "lw") ? 1 : 0);
        md_s   = uses_hilo(mn(d)) && (is_md(mn(e)) || busy);
        return data_s || md_s;
    endfunction

    // want < 0: take the model's stall; otherwise the scenario's stated value.
    task automatic step(input logic [31:0] d, e, m, input logic rst, input int want);
        exp_t x;
        string en;
        @(posedge clk);
        #1;
        D_IR  = d;
        E_IR  = e;
        M_IR  = m;
        reset = rst;
        x.cyc   = cyc;
        x.chk   = (cyc > 0);
        x.busy  = (cyc <= busy_until);
        x.stall = model_stall(d, e, m, x.busy);
        if (want >= 0) x.stall = (want != 0);
        q.push_back(x);
        en = mn(e);
        if (rst) busy_until = cyc;
        else if (en == "mult" || en == "multu") busy_until = cyc + 5;
        else if (en == "div" || en == "divu") busy_until = cyc + 10;
        cyc++;
    endtask

    task automatic cmp(input string name, input logic act, input logic req, input int c);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, c, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so one expected entry per cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.chk) begin
                    cmp("stall",    stall,    x.stall,  x.cyc);
                    cmp("PC_en",    PC_en,    ~x.stall, x.cyc);
                    cmp("FD_en",    FD_en,    ~x.stall, x.cyc);
                    cmp("DE_reset", DE_reset, x.stall,  x.cyc);
                    cmp("md_busy",  md_busy,  x.busy,   x.cyc);
                end
            end
        end
    end

    function automatic int rreg();
        int pool[5] = '{0, 1, 2, 8, 31};
        return pool[$urandom_range(0, 4)];
    endfunction

    function automatic logic [31:0] rand_ir();
        case ($urandom_range(0, 17))
            0:  return rtype(6'h21, rreg(), rreg(), rreg());
            1:  return rtype(6'h23, rreg(), rreg(), rreg());
            2:  return itype(6'h0d, rreg(), rreg(), 16'($urandom));
            3:  return itype(6'h0f, rreg(), rreg(), 16'($urandom));
            4:  return itype(6'h23, rreg(), rreg(), 16'($urandom));
            5:  return itype(6'h2b, rreg(), rreg(), 16'($urandom));
            6:  return itype(6'h04, rreg(), rreg(), 16'($urandom));
            7:  return rtype(6'h08, rreg(), 0, 0);
            8:  return {6'h03, 26'($urandom)};
            9:  return rtype(6'h18, rreg(), rreg(), 0);
            10: return rtype(6'h1b, rreg(), rreg(), 0);
            11: return rtype(6'h1a, rreg(), rreg(), 0);
            12: return rtype(6'h10, 0, 0, rreg());
            13: return rtype(6'h12, 0, 0, rreg());
            14: return rtype(6'h11, rreg(), 0, 0);
            15: return 32'h0;
            default: return 32'($urandom);
        endcase
    endfunction

    localparam logic [31:0] NOP = 32'h0;

    initial begin
        logic [31:0] lw8, addu98, beq80, mult12, div12, mflo3, mfhi4, addu9, jr9, jal0, jr31;
        logic [31:0] d, e, m;
        lw8    = itype(6'h23, 0, 8, 16'h0);
        addu98 = rtype(6'h21, 8, 1, 9);
        beq80  = itype(6'h04, 8, 0, 16'h4);
        mult12 = rtype(6'h18, 1, 2, 0);
        div12  = rtype(6'h1a, 1, 2, 0);
        mflo3  = rtype(6'h12, 0, 0, 3);
        mfhi4  = rtype(6'h10, 0, 0, 4);
        addu9  = rtype(6'h21, 1, 2, 9);
        jr9    = rtype(6'h08, 9, 0, 0);
        jal0   = {6'h03, 26'h10};
        jr31   = rtype(6'h08, 31, 0, 0);

        step(NOP, mult12, NOP, 1'b1, -1);
        step(NOP, NOP, NOP, 1'b0, 0);
        step(addu98, lw8, NOP, 1'b0, 1);
        step(addu98, NOP, lw8, 1'b0, 0);
        step(beq80, lw8, NOP, 1'b0, 1);
        step(beq80, NOP, lw8, 1'b0, 1);
        step(beq80, NOP, NOP, 1'b0, 0);
        step(itype(6'h04, 0, 0, 16'h4), itype(6'h0d, 0, 0, 16'h1), NOP, 1'b0, 0);
        step(itype(6'h2b, 2, 5, 16'h0), itype(6'h23, 0, 5, 16'h0), NOP, 1'b0, 0);
        step(jr9, addu9, NOP, 1'b0, 1);
        step(jr9, NOP, addu9, 1'b0, 0);
        step(jr31, jal0, NOP, 1'b0, 0);
        step(jr31, NOP, jal0, 1'b0, 0);
        step(mflo3, div12, NOP, 1'b0, 1);
        for (int i = 1; i <= 10; i++) step(mflo3, NOP, NOP, 1'b0, 1);
        step(mflo3, NOP, NOP, 1'b0, 0);
        step(mfhi4, mult12, NOP, 1'b0, 1);
        step(mfhi4, NOP, NOP, 1'b0, 1);
        step(mfhi4, NOP, NOP, 1'b1, 1);
        step(mfhi4, NOP, NOP, 1'b0, 0);

        for (int i = 0; i < 600; i++) begin
            d = rand_ir();
            e = rand_ir();
            m = rand_ir();
            step(d, e, m, ($urandom_range(0, 49) == 0), -1);
        end
        step(NOP, NOP, NOP, 1'b0, -1);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
